// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - I2S stereo transmitter with sample FIFO and 256-clk frame timing
// Optional AUDIO_I2S_UNDERRUN_HOLD_EN: underrun repeats the last frame sample instead of muting.
module audio_i2s_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_W   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                audio_bclk,
  output logic                audio_lrck,
  output logic                audio_dac,
  output logic [4:0]          fifo_level,
  output logic                underrun
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] FULL_LVL = 5'(FIFO_DEPTH);
  localparam logic [4:0] LAST_SLOT = 5'(SAMPLE_W);

  logic [2*SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [4:0]            level_q, level_d;
  logic [7:0]            cnt_q, cnt_d, cnt_nxt;
  logic [2*SAMPLE_W-1:0] frame_q, frame_d;
  logic                  dac_q, dac_d;
  logic                  underrun_q, underrun_d;

  logic                  push, pop_evt, pop_ok, fifo_empty;
  logic [4:0]            slot_n;
  logic [SAMPLE_W-1:0]   chan_smp, chan_shift;

  assign fifo_empty = (level_q == 5'd0);
  assign s_ready    = reset_n && (level_q != FULL_LVL);
  assign push       = s_valid && s_ready;
  assign pop_evt    = enable && (cnt_q == 8'hFF);
  assign pop_ok     = pop_evt && !fifo_empty;

  always_comb begin
    cnt_nxt    = cnt_q + 8'd1;
    cnt_d      = enable ? cnt_nxt : 8'd0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    frame_d    = frame_q;
    underrun_d = pop_evt && fifo_empty;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop_ok})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase

    if (pop_ok) begin
      frame_d = mem_q[rd_ptr_q];
    end
`ifdef AUDIO_I2S_UNDERRUN_HOLD_EN
    else if (pop_evt) begin
      frame_d = frame_q;
    end
`else
    else if (pop_evt) begin
      frame_d = '0;
    end
`endif

    // Data is launched on bclk falling for the slot that starts next cycle;
    // slot 0 of each channel is the I2S one-bit delay and always carries 0.
    slot_n     = cnt_nxt[6:2];
    chan_smp   = cnt_nxt[7] ? frame_q[SAMPLE_W-1:0] : frame_q[2*SAMPLE_W-1:SAMPLE_W];
    chan_shift = chan_smp << (slot_n - 5'd1);
    dac_d      = dac_q;
    if (!enable) begin
      dac_d = 1'b0;
    end else if (cnt_q[1:0] == 2'b11) begin
      dac_d = (slot_n != 5'd0) && (slot_n <= LAST_SLOT) && chan_shift[SAMPLE_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q      <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 5'd0;
      frame_q    <= '0;
      dac_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      frame_q    <= frame_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_left, s_right};
  end

  assign audio_bclk = cnt_q[1];
  assign audio_lrck = cnt_q[7];
  assign audio_dac  = dac_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of stereo sample entries buffered; SHALL be a power of two, 2..16.
REQ-002 Parameter SAMPLE_W, default 16, bits per channel sample; SHALL be 8..24.
REQ-003 clk  in  1  audio master clock (12.29508 MHz PLL output); sole clock; all logic SHALL be on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 enable  in  1  high = run the serial frame timing; low = hold timing idle.
REQ-006 s_valid  in  1  producer has a stereo sample on s_left/s_right.
REQ-007 s_ready  out  1  block can accept a sample; high exactly when FIFO not full and reset_n high.
REQ-008 s_left  in  SAMPLE_W  left sample, two's complement.
REQ-009 s_right  in  SAMPLE_W  right sample, two's complement.
REQ-010 audio_bclk  out  1  serial bit clock, clk/4.
REQ-011 audio_lrck  out  1  word select; 0 = left, 1 = right.
REQ-012 audio_dac  out  1  serial data, I2S format.
REQ-013 fifo_level  out  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-014 underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.

Function
REQ-015 8-bit frame counter cnt SHALL increment by 1 each clk while enable=1, wrapping 255->0; 256 clk per frame (48.03 kHz).
REQ-016 audio_bclk SHALL equal cnt[1]; audio_lrck SHALL equal cnt[7]; slot index b = cnt[6:2] (0..31).
REQ-017 audio_dac SHALL be registered, change only in the cycle cnt[1:0] goes 3->0 (bclk falling), and stay stable for all 4 clk of a slot.
REQ-018 Within each channel, slot b=0 SHALL carry 0, b=1..SAMPLE_W SHALL carry the sample MSB first, and remaining slots SHALL carry 0.
REQ-019 A push SHALL occur on any cycle with s_valid=1 and s_ready=1; the entry is {s_left,s_right}.
REQ-020 A pop SHALL occur on the cycle cnt wraps 255->0; the popped entry SHALL be latched as the frame sample for both channels of the new frame.
REQ-021 Pop with FIFO empty SHALL pulse underrun for exactly one cycle and load the underrun frame value (see Configuration).
REQ-022 Push and pop in the same cycle SHALL leave fifo_level unchanged; if FIFO was empty, the pop SHALL be an underrun and the pushed entry SHALL remain stored.
REQ-023 s_ready SHALL be 0 when fifo_level = FIFO_DEPTH; a full FIFO SHALL never be overwritten.
REQ-024 Latency: a sample pushed into an empty FIFO at cycle t SHALL be output in the first frame whose start (cnt 255->0) is at cycle t+1 or later.
REQ-025 enable=0 SHALL hold cnt at 0, hold audio_bclk/audio_lrck/audio_dac at 0, perform no pops and no underrun pulses; FIFO pushes SHALL continue.
REQ-026 On enable 0->1, the first pop SHALL occur 256 clk later; the first frame SHALL output the frame latch (zero after reset).

Reset
REQ-027 With reset_n=0 at a clk edge: cnt=0, FIFO empty, fifo_level=0, frame latch=0, audio_bclk=0, audio_lrck=0, audio_dac=0, underrun=0, s_ready=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately and discard all FIFO contents; s_ready SHALL go 1 in the first cycle after reset_n returns high.

Configuration
REQ-029 Macro AUDIO_I2S_UNDERRUN_HOLD_EN: when defined, an underrun SHALL keep the previous frame sample in the latch (repeat last sample); when undefined, an underrun SHALL load zero (mute).

Verification
REQ-030 Reset, enable=1, no pushes -> audio_bclk period 4 clk, audio_lrck period 256 clk, audio_dac constant 0, underrun pulses every 256 clk.
REQ-031 Push L=16'hA5C3, R=16'h0001 then wait a frame -> left slots 1..16 shift 1010010111000011, right slot 16 = 1, all other slots 0.
REQ-032 Hold s_valid=1 with no frame boundary -> exactly FIFO_DEPTH pushes accepted, s_ready=0, fifo_level=4; after a pop, level 3 and s_ready=1.
REQ-033 Push 16'h7FFF/16'h8000, then starve -> with AUDIO_I2S_UNDERRUN_HOLD_EN the next frame repeats 7FFF/8000; without it the frame is all zero; underrun pulses once.
REQ-034 Push on the exact cycle cnt wraps with FIFO empty -> underrun pulses, fifo_level=1, sample output in the following frame.
REQ-035 Assert reset_n=0 at cnt=100 with 3 entries queued -> all outputs 0, fifo_level=0 next cycle; after release, timing restarts from cnt=0.
